bp_dyn: RTL and testbench
=========================

Name: bp_dyn

Overview:
- Dynamic branch predictor for the fetch stage, replacing the static B-type target calculator.
- Decodes the fetched instruction and predicts direction for conditional branches using a PC-indexed table of 2-bit saturating counters (BHT).
- Predicts JAL as always taken. Predicts JALR through a direct-mapped branch target buffer (BTB).
- Tables are trained by an update port driven from branch resolution in execute.

Parameters:
- XLEN, 32, PC/instruction/target width.
- BHT_IDX_W, 6, log2 of BHT entries (64).
- BTB_IDX_W, 4, log2 of BTB entries (16).
- CNT_INIT, 2'b01, BHT counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  fetched instruction.
- pc  in  XLEN  PC of instr.
- pred_is_cf  out  1  instr is B-type, JAL or JALR.
- pred_taken  out  1  predicted taken.
- pred_target  out  XLEN  predicted next PC if taken (pc+4 when not taken).
- upd_valid  in  1  resolution update strobe.
- upd_pc  in  XLEN  PC of resolved instruction.
- upd_kind  in  2  00 none, 01 B-type, 10 JAL, 11 JALR.
- upd_taken  in  1  actual direction.
- upd_target  in  XLEN  actual target.
- upd_mispredict  in  1  execute found a misprediction.
- mispredict_cnt  out  16  saturating mispredict counter.

Behaviour:
- Reset (async on rst_n low):
  - all BHT counters = CNT_INIT;
  - all BTB valid bits = 0;
  - mispredict_cnt = 0.
- Prediction path is combinational from instr, pc and current table state (same-cycle, zero latency). Outputs are therefore defined during reset from reset-state tables.
- Decode:
  - opcode = instr[6:0]; 1100011 = B, 1101111 = JAL, 1100111 = JALR.
  - pred_is_cf = 1 for any of these, else 0.
- Immediates (sign-extended to XLEN, bit 0 = 0):
  - imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Addition is modulo 2^XLEN; wrap-around is silent.
- B-type: bidx = pc[BHT_IDX_W+1:2]; pred_taken = BHT[bidx][1]; pred_target = taken ? pc+imm_b : pc+4.
- JAL: pred_taken = 1; pred_target = pc+imm_j.
- JALR:
  - tidx = pc[BTB_IDX_W+1:2]; tag = pc[XLEN-1:BTB_IDX_W+2].
  - Hit = valid[tidx] && tag match.
  - On hit: pred_taken = 1, pred_target = BTB target.
  - On miss: pred_taken = 0, pred_target = pc+4.
- Non-control-flow instruction: pred_is_cf = 0, pred_taken = 0, pred_target = pc+4.
- Update, on rising edge with upd_valid = 1:
  - upd_kind 01: BHT[upd_pc idx] increments if upd_taken, else decrements. Saturates at 11 and 00 (11 + taken stays 11; 00 + not-taken stays 00).
  - upd_kind 11 and upd_taken = 1: write BTB[idx] = {valid = 1, tag, upd_target}, overwriting any prior entry.
  - upd_kind 11 and upd_taken = 0: no BTB change.
  - upd_kind 10 or 00: no table change.
  - upd_mispredict = 1 (with upd_valid = 1): mispredict_cnt increments, saturating at 16'hFFFF.
- upd_valid = 0: no state change; all upd_* inputs are ignored.
- Same-cycle lookup and update to the same entry: lookup returns the pre-update value (no bypass). The new value is visible from the next cycle.
- Aliasing: different PCs with equal index share one BHT entry; no tag check on the BHT.
- Reset asserted mid-operation: tables return to reset values immediately; an in-flight update on that edge is dropped.
- pc[1:0] is ignored for indexing.

Test Plan:
- Reset, then instr = 0x00000463 (beq x0,x0,+8), pc = 0x100 -> pred_is_cf = 1, pred_taken = 0, pred_target = 0x104.
- Two updates: upd_pc = 0x100, kind 01, taken = 1 -> counter 01→10→11; same lookup then gives pred_taken = 1, pred_target = 0x108. A third taken update keeps 11. Three not-taken updates go 10, 01, 00, then pred_taken = 0.
- instr = 0xFF5FF06F (jal x0,-12), pc = 0x200 -> pred_taken = 1, pred_target = 0x1F4; an update with kind 10 leaves all tables unchanged.
- JALR at pc = 0x300: before training -> taken = 0, target = 0x304. After update (kind 11, taken 1, target 0x8000) -> taken = 1, target = 0x8000. Pc = 0x340 (same tidx, different tag) -> miss.
- Update and lookup of pc = 0x100 in the same cycle -> output reflects the old counter; the next cycle reflects the new one. pc = 0x200 after the 0x100 BHT update (aliased index with BHT_IDX_W = 6) -> shares the counter.
- Assert upd_mispredict 3 times -> mispredict_cnt = 3. Drop rst_n asynchronously mid-cycle -> count = 0 and BHT back to 01 without waiting for a clock edge.

Source files
------------

// File: rtl/bp_dyn.sv
// -----------------------------------------------------------------------------
// bp_dyn : dynamic branch predictor for the fetch stage.
//
// Decodes the fetched instruction and produces a same-cycle prediction:
//   * B-type : direction from a PC-indexed table of 2-bit saturating counters
//              (BHT), target pc + imm_b when predicted taken.
//   * JAL    : always taken, target pc + imm_j.
//   * JALR   : taken only on a hit in a direct-mapped, tagged BTB.
//   * other  : not control flow, next PC is pc + 4.
// Tables are trained from branch resolution in execute through the upd_* port.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   instr, pc          fetched instruction and its PC
//   pred_is_cf         instr is B-type, JAL or JALR
//   pred_taken         predicted taken
//   pred_target        predicted next PC (pc + 4 when not taken)
//   upd_valid          resolution update strobe; all upd_* ignored when low
//   upd_pc             PC of the resolved instruction
//   upd_kind           00 none, 01 B-type, 10 JAL, 11 JALR
//   upd_taken          resolved direction
//   upd_target         resolved target
//   upd_mispredict     execute detected a misprediction
//   mispredict_cnt     saturating count of reported mispredictions
// -----------------------------------------------------------------------------
module bp_dyn #(
    parameter int         XLEN      = 32,
    parameter int         BHT_IDX_W = 6,
    parameter int         BTB_IDX_W = 4,
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic            pred_is_cf,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [1:0]      upd_kind,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    output logic [15:0]     mispredict_cnt
);

    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = XLEN - BTB_IDX_W - 2;

    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [1:0] KIND_B    = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b11;

    localparam logic [XLEN-1:0] PC_INC = XLEN'(32'd4);

    // Prediction state
    logic [1:0]       bht_r       [BHT_N];
    logic             btb_valid_r [BTB_N];
    logic [TAG_W-1:0] btb_tag_r   [BTB_N];
    logic [XLEN-1:0]  btb_tgt_r   [BTB_N];
    logic [15:0]      mis_cnt_r;

    // Lookup-side decode
    logic [6:0]           opcode_s;
    logic [XLEN-1:0]      imm_b_s;
    logic [XLEN-1:0]      imm_j_s;
    logic [XLEN-1:0]      pc_seq_s;
    logic [BHT_IDX_W-1:0] bidx_s;
    logic [BTB_IDX_W-1:0] tidx_s;
    logic [TAG_W-1:0]     tag_s;
    logic                 btb_hit_s;

    // Update-side decode
    logic [BHT_IDX_W-1:0] upd_bidx_s;
    logic [BTB_IDX_W-1:0] upd_tidx_s;
    logic [TAG_W-1:0]     upd_tag_s;
    logic [1:0]           bht_cur_s;
    logic [1:0]           bht_nxt_s;
    logic                 bht_we_s;
    logic                 btb_we_s;
    logic                 mis_inc_s;

    // pc[1:0] never participates in indexing
    logic unused_s;
    assign unused_s = ^{pc[1:0], upd_pc[1:0]};

    assign opcode_s = instr[6:0];
    // Sign bit instr[31] is included in the replication, so widths total XLEN
    assign imm_b_s  = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j_s  = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign pc_seq_s = pc + PC_INC;

    assign bidx_s    = pc[BHT_IDX_W+1:2];
    assign tidx_s    = pc[BTB_IDX_W+1:2];
    assign tag_s     = pc[XLEN-1:BTB_IDX_W+2];
    assign btb_hit_s = btb_valid_r[tidx_s] && (btb_tag_r[tidx_s] == tag_s);

    assign upd_bidx_s = upd_pc[BHT_IDX_W+1:2];
    assign upd_tidx_s = upd_pc[BTB_IDX_W+1:2];
    assign upd_tag_s  = upd_pc[XLEN-1:BTB_IDX_W+2];
    assign bht_cur_s  = bht_r[upd_bidx_s];

    assign bht_we_s  = upd_valid && (upd_kind == KIND_B);
    assign btb_we_s  = upd_valid && (upd_kind == KIND_JALR) && upd_taken;
    assign mis_inc_s = upd_valid && upd_mispredict && (mis_cnt_r != 16'hFFFF);

    assign mispredict_cnt = mis_cnt_r;

    // Same-cycle prediction from the current (pre-update) table contents
    always_comb begin
        pred_is_cf  = 1'b0;
        pred_taken  = 1'b0;
        pred_target = pc_seq_s;
        case (opcode_s)
            OP_B: begin
                pred_is_cf = 1'b1;
                pred_taken = bht_r[bidx_s][1];
                if (bht_r[bidx_s][1]) begin
                    pred_target = pc + imm_b_s;
                end else begin
                    pred_target = pc_seq_s;
                end
            end
            OP_JAL: begin
                pred_is_cf  = 1'b1;
                pred_taken  = 1'b1;
                pred_target = pc + imm_j_s;
            end
            OP_JALR: begin
                pred_is_cf = 1'b1;
                if (btb_hit_s) begin
                    pred_taken  = 1'b1;
                    pred_target = btb_tgt_r[tidx_s];
                end else begin
                    pred_taken  = 1'b0;
                    pred_target = pc_seq_s;
                end
            end
            default: begin
                pred_is_cf  = 1'b0;
                pred_taken  = 1'b0;
                pred_target = pc_seq_s;
            end
        endcase
    end

    // Saturating 2-bit counter step for the BHT entry being trained
    always_comb begin
        bht_nxt_s = bht_cur_s;
        if (upd_taken) begin
            if (bht_cur_s == 2'b11) begin
                bht_nxt_s = bht_cur_s;
            end else begin
                bht_nxt_s = bht_cur_s + 2'd1;
            end
        end else begin
            if (bht_cur_s == 2'b00) begin
                bht_nxt_s = bht_cur_s;
            end else begin
                bht_nxt_s = bht_cur_s - 2'd1;
            end
        end
    end

    // BHT counters: reset to CNT_INIT, trained by B-type resolutions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_r[i] <= CNT_INIT;
            end
        end else if (bht_we_s) begin
            bht_r[upd_bidx_s] <= bht_nxt_s;
        end
    end

    // BTB: taken JALR resolutions overwrite the indexed entry unconditionally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid_r[i] <= 1'b0;
                btb_tag_r[i]   <= '0;
                btb_tgt_r[i]   <= '0;
            end
        end else if (btb_we_s) begin
            btb_valid_r[upd_tidx_s] <= 1'b1;
            btb_tag_r[upd_tidx_s]   <= upd_tag_s;
            btb_tgt_r[upd_tidx_s]   <= upd_target;
        end
    end

    // Misprediction counter, sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_cnt_r <= 16'd0;
        end else if (mis_inc_s) begin
            mis_cnt_r <= mis_cnt_r + 16'd1;
        end
    end

endmodule

// File: tb/tb_bp_dyn.sv
// -----------------------------------------------------------------------------
// tb_bp_dyn : directed plus randomized bench for bp_dyn. A behavioural model
// keeps counters as integers 0..3, the BTB as full PCs, and the miss count
// as an int; predictions are recomputed from those and compared each cycle.
// -----------------------------------------------------------------------------
module tb_bp_dyn;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred_is_cf;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_kind;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [15:0] mispredict_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int          bht_m    [64];
    bit          btb_v_m  [16];
    logic [31:0] btb_pc_m [16];
    logic [31:0] btb_t_m  [16];
    int          cnt_m;

    bp_dyn dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr          (instr),
        .pc             (pc),
        .pred_is_cf     (pred_is_cf),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_kind       (upd_kind),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        for (int i = 0; i < 16; i++) btb_v_m[i] = 1'b0;
        cnt_m = 0;
    endtask

    task automatic model_update();
        int bi;
        int ti;
        if (upd_valid) begin
            bi = (upd_pc >> 2) % 64;
            ti = (upd_pc >> 2) % 16;
            if (upd_kind == 2'b01) begin
                if (upd_taken) bht_m[bi] = (bht_m[bi] < 3) ? bht_m[bi] + 1 : 3;
                else           bht_m[bi] = (bht_m[bi] > 0) ? bht_m[bi] - 1 : 0;
            end
            if (upd_kind == 2'b11 && upd_taken) begin
                btb_v_m[ti]  = 1'b1;
                btb_pc_m[ti] = upd_pc;
                btb_t_m[ti]  = upd_target;
            end
            if (upd_mispredict && cnt_m < 65535) cnt_m = cnt_m + 1;
        end
    endtask

    task automatic model_pred(output logic cf, output logic tk, output logic [31:0] tg);
        int imm;
        int ti;
        cf = 1'b0;
        tk = 1'b0;
        tg = pc + 32'd4;
        ti = (pc >> 2) % 16;
        case (instr[6:0])
            7'b1100011: begin
                cf  = 1'b1;
                imm = $signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
                tk  = (bht_m[(pc >> 2) % 64] >= 2);
                if (tk) tg = pc + imm;
            end
            7'b1101111: begin
                cf  = 1'b1;
                tk  = 1'b1;
                imm = $signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
                tg  = pc + imm;
            end
            7'b1100111: begin
                cf = 1'b1;
                if (btb_v_m[ti] && ((btb_pc_m[ti] >> 6) == (pc >> 6))) begin
                    tk = 1'b1;
                    tg = btb_t_m[ti];
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic        cf;
        logic        tk;
        logic [31:0] tg;
        model_pred(cf, tk, tg);
        chk({tag, ".is_cf"},  {31'd0, pred_is_cf}, {31'd0, cf});
        chk({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, tk});
        chk({tag, ".target"}, pred_target, tg);
        chk({tag, ".cnt"},    {16'd0, mispredict_cnt}, cnt_m);
    endtask

    // Check the lookup before the edge (pre-update view), clock, apply model
    task automatic step(input string tag);
        #1;
        chk_model(tag);
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    task automatic set_upd(input logic v, input logic [31:0] p, input logic [1:0] k,
                           input logic t, input logic [31:0] tg, input logic m);
        upd_valid      = v;
        upd_pc         = p;
        upd_kind       = k;
        upd_taken      = t;
        upd_target     = tg;
        upd_mispredict = m;
    endtask

    localparam logic [31:0] BEQ  = 32'h00000463;
    localparam logic [31:0] JAL  = 32'hFF5FF06F;
    localparam logic [31:0] JALR = 32'h00008067;

    initial begin
        rst_n = 1'b0;
        instr = BEQ;
        pc    = 32'h100;
        set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        model_reset();

        // Outputs are defined from reset-state tables while in reset
        #2;
        chk("rst.is_cf",  {31'd0, pred_is_cf}, 32'd1);
        chk("rst.taken",  {31'd0, pred_taken}, 32'd0);
        chk("rst.target", pred_target, 32'h104);
        chk("rst.cnt",    {16'd0, mispredict_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // BHT training 01 -> 10 -> 11, then saturate
        set_upd(1'b1, 32'h100, 2'b01, 1'b1, 32'h0, 1'b0);
        step("bht.t1");
        step("bht.t2");
        #1;
        chk("bht.11.taken",  {31'd0, pred_taken}, 32'd1);
        chk("bht.11.target", pred_target, 32'h108);
        step("bht.t3");
        #1;
        chk("bht.sat.taken", {31'd0, pred_taken}, 32'd1);
        set_upd(1'b1, 32'h100, 2'b01, 1'b0, 32'h0, 1'b0);
        step("bht.n1");
        step("bht.n2");
        step("bht.n3");
        #1;
        chk("bht.00.taken",  {31'd0, pred_taken}, 32'd0);
        chk("bht.00.target", pred_target, 32'h104);
        step("bht.n4");

        // JAL always taken; a kind-10 update leaves tables alone
        instr = JAL;
        pc    = 32'h200;
        set_upd(1'b1, 32'h100, 2'b10, 1'b1, 32'h1234, 1'b0);
        #1;
        chk("jal.taken",  {31'd0, pred_taken}, 32'd1);
        chk("jal.target", pred_target, 32'h1F4);
        step("jal.upd");
        instr = BEQ;
        pc    = 32'h100;
        set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        #1;
        chk("jal.noupd.taken", {31'd0, pred_taken}, 32'd0);
        step("jal.post");

        // JALR via BTB: miss, train, hit, tag mismatch
        instr = JALR;
        pc    = 32'h300;
        #1;
        chk("jalr.miss.taken",  {31'd0, pred_taken}, 32'd0);
        chk("jalr.miss.target", pred_target, 32'h304);
        set_upd(1'b1, 32'h300, 2'b11, 1'b1, 32'h8000, 1'b0);
        step("jalr.train");
        set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        #1;
        chk("jalr.hit.taken",  {31'd0, pred_taken}, 32'd1);
        chk("jalr.hit.target", pred_target, 32'h8000);
        pc = 32'h340;
        #1;
        chk("jalr.tag.taken",  {31'd0, pred_taken}, 32'd0);
        chk("jalr.tag.target", pred_target, 32'h344);
        step("jalr.tag");

        // Aliasing: 0x100 and 0x200 share BHT index 0 (counter 00 -> 10)
        instr = BEQ;
        pc    = 32'h200;
        set_upd(1'b1, 32'h100, 2'b01, 1'b1, 32'h0, 1'b0);
        step("alias.u1");
        step("alias.u2");
        set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        #1;
        chk("alias.taken",  {31'd0, pred_taken}, 32'd1);
        chk("alias.target", pred_target, 32'h208);

        // Same-cycle lookup/update: old value now, new value next cycle
        pc = 32'h100;
        set_upd(1'b1, 32'h100, 2'b01, 1'b0, 32'h0, 1'b0);
        #1;
        chk("bypass.old", {31'd0, pred_taken}, 32'd1);
        step("bypass.upd");
        set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        #1;
        chk("bypass.new", {31'd0, pred_taken}, 32'd0);

        // Mispredict counter; upd_valid low is ignored
        set_upd(1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1);
        step("mis.1");
        step("mis.2");
        step("mis.3");
        set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1);
        step("mis.ign");
        chk("mis.cnt", {16'd0, mispredict_cnt}, 32'd3);

        // Train to 11, then drop reset mid-cycle with an update in flight
        set_upd(1'b1, 32'h100, 2'b01, 1'b1, 32'h0, 1'b0);
        step("pre.rst1");
        step("pre.rst2");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst.cnt",   {16'd0, mispredict_cnt}, 32'd0);
        chk("arst.taken", {31'd0, pred_taken}, 32'd0);
        instr = JALR;
        pc    = 32'h300;
        #1;
        chk("arst.btb", {31'd0, pred_taken}, 32'd0);
        instr = BEQ;
        pc    = 32'h100;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        #1;
        chk("arst.drop", {31'd0, pred_taken}, 32'd0);
        step("arst.post");

        // Randomized phase against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = $urandom;
            case ($urandom_range(0, 3))
                0: instr = {r[31:7], 7'b1100011};
                1: instr = {r[31:7], 7'b1101111};
                2: instr = {r[31:7], 7'b1100111};
                default: instr = r;
            endcase
            pc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 2047));
            set_upd($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 2047)),
                    2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    $urandom,
                    $urandom_range(0, 3) == 0);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
